// File: rtl/sole_fp_pkg.sv
// Shared BF16/FP32 field widths, special-value encodings and per-lane flag/class enums
// for the BF16 squaring datapath.
package sole_fp_pkg;

  localparam int unsigned BF16_W     = 16;
  localparam int unsigned BF16_EXP_W = 8;
  localparam int unsigned BF16_MAN_W = 7;
  localparam int unsigned FP32_W     = 32;
  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned PROD_W     = 2 * (BF16_MAN_W + 1);
  localparam int unsigned FLAG_W     = 4;
  localparam int unsigned CLS_W      = 2;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] FP32_PINF = 32'h7F80_0000;

  // Bit positions inside a lane's 4-bit flag nibble {nan, ovf, uf, zero}.
  typedef enum logic [1:0] {
    FlagZero = 2'd0,
    FlagUf   = 2'd1,
    FlagOvf  = 2'd2,
    FlagNan  = 2'd3
  } flag_idx_e;

  typedef enum logic [1:0] {
    ClsNorm = 2'd0,
    ClsZero = 2'd1,
    ClsInf  = 2'd2,
    ClsNan  = 2'd3
  } sq_cls_e;

endpackage

// File: rtl/bf16_sq_lane.sv
// One BF16 squaring lane, split into a decode half (fields, exact product, class) and a finish
// half (exponent, result select, flags) so the parent can place a register between them.
module bf16_sq_lane
  import sole_fp_pkg::*;
(
  input  logic [BF16_W-1:0]     i_a,
  output logic [BF16_EXP_W-1:0] o_exp,
  output logic [PROD_W-1:0]     o_prod,
  output logic [CLS_W-1:0]      o_cls,
  input  logic [BF16_EXP_W-1:0] i_exp,
  input  logic [PROD_W-1:0]     i_prod,
  input  logic [CLS_W-1:0]      i_cls,
  output logic [FP32_W-1:0]     o_data,
  output logic [FLAG_W-1:0]     o_flags
);

  logic [BF16_EXP_W-1:0] w_exp;
  logic [BF16_MAN_W-1:0] w_man;
  logic [BF16_MAN_W:0]   w_sig;
  logic                  w_unused_sign;

  assign w_exp         = i_a[BF16_W-2:BF16_MAN_W];
  assign w_man         = i_a[BF16_MAN_W-1:0];
  assign w_sig         = {1'b1, w_man};
  assign w_unused_sign = i_a[BF16_W-1];
  assign o_exp         = w_exp;
  assign o_prod        = PROD_W'(w_sig) * PROD_W'(w_sig);

  always_comb begin
    if (w_exp == '1) begin
      o_cls = (w_man != '0) ? ClsNan : ClsInf;
    end else if (w_exp == '0) begin
      o_cls = ClsZero;
    end else begin
      o_cls = ClsNorm;
    end
  end

  logic                    w_inc;
  logic [FP32_MAN_W-1:0]   w_mant;
  logic signed [9:0]       w_er;

  assign w_inc  = i_prod[PROD_W-1];
  assign w_mant = w_inc ? {i_prod[PROD_W-2:0], 8'b0} : {i_prod[PROD_W-3:0], 9'b0};
  // 2E as a non-negative 10-bit value, then rebias; range -125..382 fits signed 10 bits.
  assign w_er   = $signed({1'b0, i_exp, 1'b0}) - 10'sd127 + $signed({9'b0, w_inc});

  always_comb begin
    o_data  = '0;
    o_flags = '0;
    unique case (i_cls)
      ClsNan: begin
        o_data           = FP32_QNAN;
        o_flags[FlagNan] = 1'b1;
      end
      ClsInf:  o_data = FP32_PINF;
      ClsZero: o_flags[FlagZero] = 1'b1;
      default: begin
        if (w_er >= 10'sd255) begin
          o_data           = FP32_PINF;
          o_flags[FlagOvf] = 1'b1;
        end else if (w_er <= 10'sd0) begin
          o_flags[FlagUf]   = 1'b1;
          o_flags[FlagZero] = 1'b1;
        end else begin
          o_data = {1'b0, w_er[FP32_EXP_W-1:0], w_mant};
        end
      end
    endcase
  end

endmodule

// File: rtl/bf16_square_vec.sv
// Vector BF16 -> FP32 squaring unit: LANES lanes, 1- or 2-stage valid/ready pipeline and
// saturating overflow/underflow lane counters.
module bf16_square_vec
  import sole_fp_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BF16_W*LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP32_W*LANES-1:0] out_data,
  output logic [FLAG_W*LANES-1:0] out_flags,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        ovf_cnt,
  output logic [CNT_W-1:0]        uf_cnt
);

  localparam int unsigned POP_W = $clog2(LANES + 1);

  logic [LANES-1:0][BF16_EXP_W-1:0] w_dec_exp, w_fin_exp;
  logic [LANES-1:0][PROD_W-1:0]     w_dec_prod, w_fin_prod;
  logic [LANES-1:0][CLS_W-1:0]      w_dec_cls, w_fin_cls;
  logic [FP32_W*LANES-1:0]          w_data;
  logic [FLAG_W*LANES-1:0]          w_flags;
  logic                             w_src_valid;
  logic                             w_ld_out;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bf16_sq_lane u_lane (
      .i_a     (in_data[BF16_W*g +: BF16_W]),
      .o_exp   (w_dec_exp[g]),
      .o_prod  (w_dec_prod[g]),
      .o_cls   (w_dec_cls[g]),
      .i_exp   (w_fin_exp[g]),
      .i_prod  (w_fin_prod[g]),
      .i_cls   (w_fin_cls[g]),
      .o_data  (w_data[FP32_W*g +: FP32_W]),
      .o_flags (w_flags[FLAG_W*g +: FLAG_W])
    );
  end

  logic                     r_out_valid;
  logic [FP32_W*LANES-1:0]  r_out_data;
  logic [FLAG_W*LANES-1:0]  r_out_flags;

  assign w_ld_out = !r_out_valid || out_ready;

  if (PIPE_STAGES == 2) begin : g_s1
    logic                             r_v1;
    logic [LANES-1:0][BF16_EXP_W-1:0] r_exp;
    logic [LANES-1:0][PROD_W-1:0]     r_prod;
    logic [LANES-1:0][CLS_W-1:0]      r_cls;
    logic                             w_ld1;

    assign w_ld1 = !r_v1 || w_ld_out;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v1   <= 1'b0;
        r_exp  <= '0;
        r_prod <= '0;
        r_cls  <= '0;
      end else if (w_ld1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_exp  <= w_dec_exp;
          r_prod <= w_dec_prod;
          r_cls  <= w_dec_cls;
        end
      end
    end

    assign in_ready    = w_ld1;
    assign w_src_valid = r_v1;
    assign w_fin_exp   = r_exp;
    assign w_fin_prod  = r_prod;
    assign w_fin_cls   = r_cls;
  end else begin : g_s0
    assign in_ready    = w_ld_out;
    assign w_src_valid = in_valid;
    assign w_fin_exp   = w_dec_exp;
    assign w_fin_prod  = w_dec_prod;
    assign w_fin_cls   = w_dec_cls;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else if (w_ld_out) begin
      r_out_valid <= w_src_valid;
      if (w_src_valid) begin
        r_out_data  <= w_data;
        r_out_flags <= w_flags;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

  logic [CNT_W-1:0] r_ovf_cnt, r_uf_cnt;
  logic [POP_W-1:0] w_ovf_pop, w_uf_pop;
  logic [CNT_W:0]   w_ovf_sum, w_uf_sum;

  always_comb begin
    w_ovf_pop = '0;
    w_uf_pop  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_ovf_pop = w_ovf_pop + POP_W'(r_out_flags[FLAG_W*i + int'(FlagOvf)]);
      w_uf_pop  = w_uf_pop + POP_W'(r_out_flags[FLAG_W*i + int'(FlagUf)]);
    end
    w_ovf_sum = {1'b0, r_ovf_cnt} + (CNT_W+1)'(w_ovf_pop);
    w_uf_sum  = {1'b0, r_uf_cnt} + (CNT_W+1)'(w_uf_pop);
  end

  // A popcount never exceeds 2^CNT_W, so a carry out of the sum means saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
      r_uf_cnt  <= '0;
    end else if (cnt_clr) begin
      r_ovf_cnt <= '0;
      r_uf_cnt  <= '0;
    end else if (r_out_valid && out_ready) begin
      r_ovf_cnt <= w_ovf_sum[CNT_W] ? '1 : w_ovf_sum[CNT_W-1:0];
      r_uf_cnt  <= w_uf_sum[CNT_W] ? '1 : w_uf_sum[CNT_W-1:0];
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign uf_cnt  = r_uf_cnt;

endmodule
